// File: rtl/mul_seq_shift_add.sv
// Sequential shift-and-add unsigned multiplier controller driving an external WIDTH-bit adder.
// Optional MUL_ZERO_BYPASS_EN: zero operands skip RUN and go straight to FIN.
module mul_seq_shift_add #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] PROD,
    output logic [WIDTH-1:0]   ADD_A,
    output logic [WIDTH-1:0]   ADD_B,
    output logic               ADD_P,
    input  logic [WIDTH-1:0]   ADD_S,
    input  logic               ADD_CO
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   h;
    logic [WIDTH-1:0]   l;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] shifted;
    logic               zero_op;

    // Carry-out lands in the top bit of H, so the full (WIDTH+1)-bit sum is kept.
    assign shifted = {ADD_CO, ADD_S, l[WIDTH-1:1]};

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_op = (X == '0) || (Y == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        ADD_A = '0;
        ADD_B = '0;
        ADD_P = 1'b0;
        if (state == RUN) begin
            ADD_A = h;
            ADD_B = l[0] ? m : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            PROD  <= '0;
            m     <= '0;
            h     <= '0;
            l     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        m   <= X;
                        h   <= '0;
                        l   <= Y;
                        cnt <= '0;
                        if (zero_op) begin
                            state <= FIN;
                            DONE  <= 1'b1;
                            PROD  <= '0;
                        end else begin
                            state <= RUN;
                            BUSY  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    {h, l} <= shifted;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Product is captured on FIN entry so it is valid alongside DONE.
                        state <= FIN;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        PROD  <= shifted;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_shift_add.sv
// Self-checking bench for mul_seq_shift_add: the adder is modelled here, products checked against x*y.
module tb_mul_seq_shift_add;

    localparam int W = 4;
`ifdef MUL_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           RST;
    logic           START;
    logic [W-1:0]   X;
    logic [W-1:0]   Y;
    logic           BUSY;
    logic           DONE;
    logic [2*W-1:0] PROD;
    logic [W-1:0]   ADD_A;
    logic [W-1:0]   ADD_B;
    logic           ADD_P;
    logic [W-1:0]   ADD_S;
    logic           ADD_CO;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mul_seq_shift_add #(.WIDTH(W), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST), .START(START), .X(X), .Y(Y),
        .BUSY(BUSY), .DONE(DONE), .PROD(PROD),
        .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_P(ADD_P),
        .ADD_S(ADD_S), .ADD_CO(ADD_CO)
    );

    // External adder/subtractor: P=1 would subtract, P=0 adds.
    always_comb begin
        if (ADD_P) {ADD_CO, ADD_S} = {1'b0, ADD_A} - {1'b0, ADD_B};
        else       {ADD_CO, ADD_S} = {1'b0, ADD_A} + {1'b0, ADD_B};
    end

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] prod;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        return (BYP && (x == 0 || y == 0)) ? 0 : W;
    endfunction

    // Waits (bounded) for DONE; returns cycles after the current sample.
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (!DONE && lat < 20) begin
            if (BUSY) busy_n++;
            if (ADD_P !== 1'b0) check("add_p_zero", 32'(ADD_P), 0);
            if (!BUSY) check("adder_idle_zero", {ADD_A, ADD_B}, 0);
            tick();
            lat++;
        end
        check("done_seen", 32'(DONE), 1);
    endtask

    // One full operation from IDLE back to IDLE with the model's expectations.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        int lat, busy_n;
        logic [2*W-1:0] p;
        START = 1'b1; X = x; Y = y;
        tick();
        START = 1'b0;
        X = W'($urandom); Y = W'($urandom);
        wait_done(lat, busy_n);
        p = PROD;
        check({tag, "_prod"}, 32'(p), 32'(x) * 32'(y));
        check({tag, "_lat"}, lat, exp_lat(x, y));
        check({tag, "_busy"}, busy_n, exp_lat(x, y));
        check({tag, "_fin_busy"}, 32'(BUSY), 0);
        tick();
        check({tag, "_done_pulse"}, 32'(DONE), 0);
        check({tag, "_prod_hold"}, 32'(PROD), 32'(p));
    endtask

    initial begin
        int lat, busy_n, t1, t2;
        logic [W-1:0] rx, ry;

        vecs[0] = '{4'd3,  4'd5,  8'h0F};
        vecs[1] = '{4'd15, 4'd15, 8'hE1};
        vecs[2] = '{4'd9,  4'd0,  8'h00};
        vecs[3] = '{4'd7,  4'd6,  8'h2A};
        vecs[4] = '{4'd2,  4'd8,  8'h10};
        vecs[5] = '{4'd13, 4'd11, 8'h8F};
        vecs[6] = '{4'd0,  4'd0,  8'h00};
        vecs[7] = '{4'd1,  4'd15, 8'h0F};

        RST = 1'b1; START = 1'b0; X = '0; Y = '0;
        tick();
        tick();
        check("rst_busy", 32'(BUSY), 0);
        check("rst_done", 32'(DONE), 0);
        check("rst_prod", 32'(PROD), 0);
        check("rst_adder", {ADD_P, ADD_A, ADD_B}, 0);
        RST = 1'b0;
        tick();

        // Table vectors: fixed expected product plus model latency.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].x, vecs[i].y, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_table", i), 32'(PROD), 32'(vecs[i].prod));
        end

        // 15*15 product must hold while idle.
        run_op(4'd15, 4'd15, "hold");
        repeat (10) tick();
        check("hold_10", 32'(PROD), 32'hE1);

        // START held through RUN with operands changing mid-operation.
        START = 1'b1; X = 4'd7; Y = 4'd6;
        tick();
        X = 4'd1; Y = 4'd1;
        wait_done(lat, busy_n);
        check("held_prod", 32'(PROD), 32'h2A);
        check("held_lat", lat, W);
        tick();
        check("held_idle_busy", 32'(BUSY), 0);
        check("held_idle_done", 32'(DONE), 0);
        tick();
        check("held_second_start", 32'(BUSY), 1);
        START = 1'b0;
        wait_done(lat, busy_n);
        check("held_second_prod", 32'(PROD), 32'h01);
        tick();

        // Reset in the second RUN cycle aborts without DONE.
        START = 1'b1; X = 4'd13; Y = 4'd11;
        tick();
        START = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort_busy", 32'(BUSY), 0);
        check("abort_done", 32'(DONE), 0);
        check("abort_prod", 32'(PROD), 0);
        busy_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (DONE || BUSY) busy_n++;
            tick();
        end
        check("abort_quiet", busy_n, 0);

        // Back-to-back: START raised during FIN is taken on the following IDLE edge.
        START = 1'b1; X = 4'd3; Y = 4'd5;
        tick();
        START = 1'b0;
        wait_done(lat, busy_n);
        t1 = cyc;
        check("b2b_first", 32'(PROD), 32'h0F);
        START = 1'b1; X = 4'd2; Y = 4'd8;
        tick();
        check("b2b_fin_ignored", 32'(BUSY), 0);
        tick();
        START = 1'b0;
        check("b2b_second_busy", 32'(BUSY), 1);
        wait_done(lat, busy_n);
        t2 = cyc;
        check("b2b_second", 32'(PROD), 32'h10);
        check("b2b_spacing", t2 - t1, W + 2);
        tick();

        // Random operands against x*y.
        for (int i = 0; i < 40; i++) begin
            rx = W'($urandom_range(0, 15));
            ry = W'($urandom_range(0, 15));
            run_op(rx, ry, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
